// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with prescaler, edge/center counting and shadowed period/mode/duty
`timescale 1ns/1ps

module pwm_multi #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PRESC_W-1:0]        presc,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          period,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      e,
  output logic [WIDTH-1:0]          tcr,
  output logic                      upd_pend
);

  logic [1:0]                sync_q, sync_d;
  logic [PRESC_W-1:0]        presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]          tcr_q, tcr_d;
  logic                      dir_q, dir_d;
  logic                      pend_q, pend_d;
  logic [WIDTH-1:0]          st_period_q, st_period_d;
  logic                      st_mode_q, st_mode_d;
  logic [CHANNELS*WIDTH-1:0] st_duty_q, st_duty_d;
  logic [WIDTH-1:0]          act_period_q, act_period_d;
  logic                      act_mode_q, act_mode_d;
  logic [CHANNELS*WIDTH-1:0] act_duty_q, act_duty_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      e_q, e_d;

  logic run;
  logic tick;
  logic start;
  logic transfer;

  // Counting is held off until the reset release has passed through two flops.
  assign run  = en & sync_q[1];
  assign tick = run && (presc_cnt_q == presc);

  always_comb begin
    sync_d      = {sync_q[0], 1'b1};
    presc_cnt_d = (!run || tick) ? '0 : presc_cnt_q + 1'b1;
    tcr_d       = tcr_q;
    dir_d       = dir_q;
    start       = 1'b0;

    if (!run) begin
      tcr_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (act_period_q == '0) begin
        tcr_d = '0;
        start = 1'b1;
      end else if (!act_mode_q) begin
        if (tcr_q >= act_period_q) begin
          tcr_d = '0;
          start = 1'b1;
        end else begin
          tcr_d = tcr_q + 1'b1;
        end
      end else if (!dir_q) begin
        if (tcr_q >= act_period_q) begin
          tcr_d = act_period_q - 1'b1;
          if (act_period_q == WIDTH'(1)) start = 1'b1;
          else dir_d = 1'b1;
        end else begin
          tcr_d = tcr_q + 1'b1;
        end
      end else begin
        if (tcr_q <= WIDTH'(1)) begin
          tcr_d = '0;
          start = 1'b1;
        end else begin
          tcr_d = tcr_q - 1'b1;
        end
      end
      if (start) dir_d = 1'b0;
    end

    // A write landing on the transfer edge stays pending; the transfer takes the older staging.
    transfer     = pend_q && (start || !run);
    act_period_d = transfer ? st_period_q : act_period_q;
    act_mode_d   = transfer ? st_mode_q   : act_mode_q;
    act_duty_d   = transfer ? st_duty_q   : act_duty_q;

    st_period_d = wr ? period : st_period_q;
    st_mode_d   = wr ? mode   : st_mode_q;
    st_duty_d   = wr ? duty   : st_duty_q;
    pend_d      = wr ? 1'b1 : (transfer ? 1'b0 : pend_q);

    e_d   = start;
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = run && (tcr_q < act_duty_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      presc_cnt_q  <= '0;
      tcr_q        <= '0;
      dir_q        <= 1'b0;
      pend_q       <= 1'b0;
      st_period_q  <= '1;
      st_mode_q    <= 1'b0;
      st_duty_q    <= '0;
      act_period_q <= '1;
      act_mode_q   <= 1'b0;
      act_duty_q   <= '0;
      pwm_q        <= '0;
      e_q          <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      presc_cnt_q  <= presc_cnt_d;
      tcr_q        <= tcr_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      st_period_q  <= st_period_d;
      st_mode_q    <= st_mode_d;
      st_duty_q    <= st_duty_d;
      act_period_q <= act_period_d;
      act_mode_q   <= act_mode_d;
      act_duty_q   <= act_duty_d;
      pwm_q        <= pwm_d;
      e_q          <= e_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign e        = e_q;
  assign tcr      = tcr_q;
  assign upd_pend = pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - table-driven and directed-sequence bench for pwm_multi
`timescale 1ns/1ps

module tb_pwm_multi;
  localparam int WIDTH    = 7;
  localparam int CHANNELS = 4;
  localparam int PRESC_W  = 11;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      en = 1'b0;
  logic [PRESC_W-1:0]        presc = '0;
  logic                      wr = 1'b0;
  logic [WIDTH-1:0]          period = '0;
  logic                      mode = 1'b0;
  logic [CHANNELS*WIDTH-1:0] duty = '0;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      e;
  logic [WIDTH-1:0]          tcr;
  logic                      upd_pend;

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .presc(presc), .wr(wr), .period(period),
    .mode(mode), .duty(duty), .pwm_out(pwm_out), .e(e), .tcr(tcr), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int presc; int period; int mode;
    int d0; int d1; int d2; int d3;
    int len;
    int h0; int h1; int h2; int h3;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   hi_cnt [CHANNELS];
  int   tcr_seq [64];
  int   per_len;
  bit   pend_all;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic write_cfg(input int p, input int m, input int d0, input int d1, input int d2, input int d3);
    period = WIDTH'(p);
    mode   = m[0];
    duty[0*WIDTH +: WIDTH] = WIDTH'(d0);
    duty[1*WIDTH +: WIDTH] = WIDTH'(d1);
    duty[2*WIDTH +: WIDTH] = WIDTH'(d2);
    duty[3*WIDTH +: WIDTH] = WIDTH'(d3);
    wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_e(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (e) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called while E is sampled high; counts one full period up to the next E.
  task automatic measure();
    per_len  = 0;
    pend_all = 1'b1;
    for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
    do begin
      for (int c = 0; c < CHANNELS; c++) hi_cnt[c] += int'(pwm_out[c]);
      if (per_len < 64) tcr_seq[per_len] = int'(tcr);
      pend_all &= upd_pend;
      per_len++;
      step();
    end while (!e && per_len < 400);
  endtask

  initial begin
    bit ok;
    bit last_pend;
    int h;
    int n;
    int cseq [8];

    vecs[0] = '{0, 9, 0,  0, 3, 10, 5,  10,  0,  3, 10,  5};
    vecs[1] = '{3, 9, 0,  0, 3, 10, 5,  40,  0, 12, 40, 20};
    vecs[2] = '{0, 4, 1,  2, 0,  5, 4,   8,  3,  0,  8,  7};
    vecs[3] = '{0, 0, 0,  0, 1,  0, 1,   1,  0,  1,  0,  1};
    vecs[4] = '{1, 3, 1,  1, 3,  4, 2,  12,  2, 10, 12,  6};
    vecs[5] = '{0, 1, 0,  0, 1,  2, 1,   2,  0,  1,  2,  1};
    cseq    = '{0, 1, 2, 3, 4, 3, 2, 1};

    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_e", int'(e), 0);
    chk("rst_tcr", int'(tcr), 0);
    chk("rst_pend", int'(upd_pend), 0);

    for (int v = 0; v < 6; v++) begin
      en = 1'b0;
      do_reset();
      presc = PRESC_W'(vecs[v].presc);
      write_cfg(vecs[v].period, vecs[v].mode, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
      chk($sformatf("v%0d_pend_set", v), int'(upd_pend), 1);
      step();
      chk($sformatf("v%0d_pend_idle_xfer", v), int'(upd_pend), 0);
      en = 1'b1;
      wait_e(1000, ok);
      chk($sformatf("v%0d_first_e", v), int'(ok), 1);
      step();
      wait_e(1000, ok);
      chk($sformatf("v%0d_second_e", v), int'(ok), 1);
      measure();
      chk($sformatf("v%0d_len", v), per_len, vecs[v].len);
      chk($sformatf("v%0d_hi0", v), hi_cnt[0], vecs[v].h0);
      chk($sformatf("v%0d_hi1", v), hi_cnt[1], vecs[v].h1);
      chk($sformatf("v%0d_hi2", v), hi_cnt[2], vecs[v].h2);
      chk($sformatf("v%0d_hi3", v), hi_cnt[3], vecs[v].h3);
      if (v == 2) begin
        for (int i = 0; i < 8; i++) chk($sformatf("center_tcr%0d", i), tcr_seq[i], cseq[i]);
        for (int i = 1; i < 8; i++) chk($sformatf("center_sym%0d", i), tcr_seq[i], tcr_seq[8-i]);
      end
    end

    // Shadow timing: mid-period write of ch1=7 while ch1=3 is active.
    en = 1'b0;
    do_reset();
    presc = '0;
    write_cfg(9, 0, 0, 3, 10, 5);
    step();
    en = 1'b1;
    wait_e(200, ok);
    chk("sh_e", int'(ok), 1);
    h = 0;
    for (int i = 0; i < 4; i++) begin
      h += int'(pwm_out[1]);
      step();
    end
    chk("sh_pend_before", int'(upd_pend), 0);
    h += int'(pwm_out[1]);
    write_cfg(9, 0, 0, 7, 10, 5);
    chk("sh_pend_after_wr", int'(upd_pend), 1);
    n = 0;
    last_pend = 1'b0;
    while (!e && n < 50) begin
      h += int'(pwm_out[1]);
      last_pend = upd_pend;
      n++;
      step();
    end
    chk("sh_start_reached", int'(e), 1);
    chk("sh_pend_until_start", int'(last_pend), 1);
    chk("sh_pend_clear", int'(upd_pend), 0);
    chk("sh_cur_width", h, 3);
    measure();
    chk("sh_next_width", hi_cnt[1], 7);
    chk("sh_next_len", per_len, 10);

    // Write coinciding with a period-start transfer.
    repeat (3) step();
    write_cfg(9, 0, 0, 5, 10, 5);
    n = 0;
    while (tcr != WIDTH'(9) && n < 50) begin
      n++;
      step();
    end
    chk("co_tcr9_reached", int'(tcr), 9);
    write_cfg(9, 0, 0, 2, 10, 5);
    chk("co_e", int'(e), 1);
    chk("co_pend_stays", int'(upd_pend), 1);
    measure();
    chk("co_old_width", hi_cnt[1], 5);
    chk("co_pend_between", int'(pend_all), 1);
    chk("co_pend_clear", int'(upd_pend), 0);
    measure();
    chk("co_new_width", hi_cnt[1], 2);

    // Enable low: hold, accept writes, immediate transfer; restart delay with PRESC=3.
    en = 1'b0;
    step();
    chk("en0_tcr", int'(tcr), 0);
    chk("en0_pwm", int'(pwm_out), 0);
    chk("en0_e", int'(e), 0);
    step();
    chk("en0_tcr2", int'(tcr), 0);
    write_cfg(9, 0, 0, 3, 10, 5);
    chk("en0_pend_set", int'(upd_pend), 1);
    step();
    chk("en0_pend_clear", int'(upd_pend), 0);
    presc = PRESC_W'(3);
    en = 1'b1;
    step();
    chk("en1_tcr_e1", int'(tcr), 0);
    chk("en1_pwm_e1", int'(pwm_out), 14);
    step();
    chk("en1_tcr_e2", int'(tcr), 0);
    step();
    chk("en1_tcr_e3", int'(tcr), 0);
    step();
    chk("en1_tcr_e4", int'(tcr), 1);

    // Asynchronous reset mid-period with an update pending.
    presc = '0;
    repeat (5) step();
    write_cfg(9, 0, 5, 5, 5, 5);
    chk("ar_pend_before", int'(upd_pend), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pwm", int'(pwm_out), 0);
    chk("ar_e", int'(e), 0);
    chk("ar_tcr", int'(tcr), 0);
    chk("ar_pend", int'(upd_pend), 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_rel_tcr1", int'(tcr), 0);
    step();
    chk("ar_rel_tcr2", int'(tcr), 0);
    wait_e(300, ok);
    chk("ar_e_seen", int'(ok), 1);
    measure();
    chk("ar_len", per_len, 128);
    chk("ar_pwm_all0", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
    chk("ar_no_pend", int'(upd_pend), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
